// File: rtl/heu_window_rx.sv
// HEU-side window receiver: 2-slot ping-pong capture of 20x20 windows,
// replayed as 20 rows over a valid/ready stream.
module heu_window_rx #(
    parameter int PIX_W   = 8,
    parameter int WIN_DIM = 20,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vldIpgu,
    input  logic [4:0][79:0][PIX_W-1:0]  ipguOutBufferQ,
    output logic                         rdyHeu,
    output logic                         rowVld,
    input  logic                         rowRdy,
    output logic [19:0][PIX_W-1:0]       rowData,
    output logic [4:0]                   rowIdx,
    output logic                         rowFirst,
    output logic                         rowLast,
    output logic [CNT_W-1:0]             winCnt
);

    if (WIN_DIM != 20) begin : gBadDim
        $error("heu_window_rx supports WIN_DIM == 20 only");
    end

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, stateNext;

    logic [4:0][79:0][PIX_W-1:0] slotMem [2];
    logic [1:0] full, fullNext;
    logic       wrPtr, rdPtr;
    logic       accept, xfer, lastXfer;
    logic       otherReady;
    logic [6:0] rowBase;

    assign rdyHeu   = rst_n && !(full[0] && full[1]);
    assign accept   = vldIpgu && rdyHeu;
    assign xfer     = rowVld && rowRdy;
    assign lastXfer = xfer && (rowIdx == 5'd19);

    // Slot landing on this edge counts as ready, so no bubble between windows.
    assign otherReady = full[~rdPtr] || (accept && (wrPtr != rdPtr));

    always_comb begin
        fullNext = full;
        if (lastXfer) fullNext[rdPtr] = 1'b0;
        if (accept)   fullNext[wrPtr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) slotMem[wrPtr] <= ipguOutBufferQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (full[rdPtr] || (accept && (wrPtr == rdPtr)))
                    stateNext = STREAM;
            end
            STREAM: begin
                if (lastXfer && !otherReady)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        rowVld   = (state == STREAM);
        rowFirst = rowVld && (rowIdx == 5'd0);
        rowLast  = rowVld && (rowIdx == 5'd19);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 2'b00;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            rowIdx <= 5'd0;
            winCnt <= '0;
        end else begin
            full <= fullNext;
            if (accept) wrPtr <= ~wrPtr;
            if (lastXfer) begin
                rdPtr  <= ~rdPtr;
                rowIdx <= 5'd0;
                winCnt <= winCnt + CNT_W'(1);
            end else if (xfer) begin
                rowIdx <= rowIdx + 5'd1;
            end
        end
    end

    // Row r lives in word r/4 at pixel offset (r%4)*20.
    assign rowBase = {1'b0, rowIdx[1:0], 4'b0000}
                   + {3'b000, rowIdx[1:0], 2'b00};

    assign rowData = slotMem[rdPtr][rowIdx[4:2]][rowBase +: 20];

endmodule

// File: tb/tb_heu_window_rx.sv
// Bench for heu_window_rx: directed vector table, corner sequences,
// and random traffic against a queue-based window model.
module tb_heu_window_rx;

    localparam int PW = 8;

    typedef logic [4:0][79:0][PW-1:0] win_t;
    typedef logic [19:0][PW-1:0]      row_t;

    typedef struct {
        logic vld;
        logic rrdy;
        logic eVld;
        int   eIdx;
        logic eRdy;
        int   eCnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vldIpgu = 1'b0;
    logic rowRdy = 1'b0;
    win_t ipguOutBufferQ = '0;
    logic rdyHeu, rowVld, rowFirst, rowLast;
    row_t rowData;
    logic [4:0] rowIdx;
    logic [15:0] winCnt;

    int errors = 0;
    int checks = 0;

    win_t q[$];
    int mRow = 0;
    int mCnt = 0;

    always #5 clk = ~clk;

    heu_window_rx #(.PIX_W(PW), .WIN_DIM(20), .CNT_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vldIpgu(vldIpgu),
        .ipguOutBufferQ(ipguOutBufferQ),
        .rdyHeu(rdyHeu),
        .rowVld(rowVld),
        .rowRdy(rowRdy),
        .rowData(rowData),
        .rowIdx(rowIdx),
        .rowFirst(rowFirst),
        .rowLast(rowLast),
        .winCnt(winCnt)
    );

    function automatic row_t rowOf(win_t w, int r);
        row_t x;
        for (int k = 0; k < 20; k++) x[k] = w[r / 4][(r % 4) * 20 + k];
        return x;
    endfunction

    function automatic win_t rampWin();
        win_t w;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                w[r / 4][(r % 4) * 20 + c] = PW'(r * 20 + c);
        return w;
    endfunction

    function automatic win_t randWin();
        win_t w;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 80; j++)
                w[i][j] = PW'($urandom);
        return w;
    endfunction

    // Window-level model: FIFO of up to two windows, head streams row by row.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mRow = 0;
            mCnt = 0;
        end else begin
            bit acc, xf;
            acc = vldIpgu && (q.size() < 2);
            xf  = (q.size() > 0) && rowRdy;
            if (xf) begin
                if (mRow == 19) begin
                    void'(q.pop_front());
                    mRow = 0;
                    mCnt++;
                end else begin
                    mRow++;
                end
            end
            if (acc) q.push_back(ipguOutBufferQ);
        end
    end

    task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmpModel();
        chk("m_rdyHeu", 160'(rdyHeu), 160'(rst_n && (q.size() < 2)));
        chk("m_rowVld", 160'(rowVld), 160'(q.size() > 0));
        chk("m_winCnt", 160'(winCnt), 160'(16'(mCnt)));
        if (q.size() > 0) begin
            chk("m_rowIdx", 160'(rowIdx), 160'(mRow));
            chk("m_rowData", 160'(rowData), 160'(rowOf(q[0], mRow)));
            chk("m_rowFirst", 160'(rowFirst), 160'(mRow == 0));
            chk("m_rowLast", 160'(rowLast), 160'(mRow == 19));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cmpModel();
    endtask

    task automatic drain(string name);
        rowRdy = 1'b1;
        for (int n = 0; n < 100 && rowVld; n++) step();
        chk(name, 160'(rowVld), 160'(0));
    endtask

    task automatic load2(win_t a, win_t b);
        rowRdy = 1'b0;
        vldIpgu = 1'b1;
        ipguOutBufferQ = a;
        step();
        ipguOutBufferQ = b;
        step();
        vldIpgu = 1'b0;
    endtask

    task automatic runTo(string name, int idx);
        rowRdy = 1'b1;
        for (int n = 0; n < 40 && rowIdx != 5'(idx); n++) step();
        chk(name, 160'(rowIdx), 160'(idx));
    endtask

    vec_t tv[22];
    row_t saved, expRow;
    int acc, accStep, beats, cnt0;
    logic a;
    win_t w3[3];

    initial begin
        tv[0] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 0};
        tv[1] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 0};
        for (int i = 0; i < 19; i++)
            tv[2 + i] = '{1'b0, 1'b1, 1'b1, i + 1, 1'b1, 0};
        tv[21] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1};

        step();
        chk("rst_rowVld", 160'(rowVld), 160'(0));
        chk("rst_rdyHeu", 160'(rdyHeu), 160'(0));
        chk("rst_winCnt", 160'(winCnt), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdyHeu", 160'(rdyHeu), 160'(1));

        ipguOutBufferQ = rampWin();
        for (int i = 0; i < 22; i++) begin
            vldIpgu = tv[i].vld;
            rowRdy  = tv[i].rrdy;
            step();
            chk("tv_rowVld", 160'(rowVld), 160'(tv[i].eVld));
            chk("tv_rdyHeu", 160'(rdyHeu), 160'(tv[i].eRdy));
            chk("tv_winCnt", 160'(winCnt), 160'(tv[i].eCnt));
            if (tv[i].eVld) begin
                for (int k = 0; k < 20; k++)
                    expRow[k] = PW'(tv[i].eIdx * 20 + k);
                chk("tv_rowIdx", 160'(rowIdx), 160'(tv[i].eIdx));
                chk("tv_rowData", 160'(rowData), 160'(expRow));
                chk("tv_first", 160'(rowFirst), 160'(tv[i].eIdx == 0));
                chk("tv_last", 160'(rowLast), 160'(tv[i].eIdx == 19));
            end
        end

        // Backpressure at row 7
        ipguOutBufferQ = randWin();
        vldIpgu = 1'b1;
        rowRdy = 1'b0;
        step();
        vldIpgu = 1'b0;
        runTo("bp_reach", 7);
        rowRdy = 1'b0;
        saved = rowData;
        repeat (10) step();
        chk("bp_idx", 160'(rowIdx), 160'(7));
        chk("bp_data", 160'(rowData), 160'(saved));
        drain("bp_drain");

        // Fill: three windows offered, only two fit
        for (int i = 0; i < 3; i++) w3[i] = randWin();
        rowRdy = 1'b0;
        acc = 0;
        accStep = -1;
        vldIpgu = 1'b1;
        ipguOutBufferQ = w3[0];
        for (int n = 0; n < 10; n++) begin
            a = rdyHeu;
            step();
            if (a) begin
                acc++;
                ipguOutBufferQ = w3[acc];
            end
        end
        chk("fill_acc2", 160'(acc), 160'(2));
        chk("fill_rdy0", 160'(rdyHeu), 160'(0));
        rowRdy = 1'b1;
        for (int n = 1; n <= 40 && acc < 3; n++) begin
            a = rdyHeu;
            step();
            if (a) begin
                acc++;
                accStep = n;
                vldIpgu = 1'b0;
            end
        end
        chk("fill_acc3", 160'(acc), 160'(3));
        chk("fill_lat", 160'(accStep), 160'(21));
        vldIpgu = 1'b0;
        drain("fill_drain");

        // Streaming two stored windows back to back
        load2(randWin(), randWin());
        rowRdy = 1'b1;
        cnt0 = int'(winCnt);
        beats = 0;
        for (int n = 0; n < 45; n++) begin
            if (rowVld) beats++;
            step();
        end
        chk("str_beats", 160'(beats), 160'(40));
        chk("str_cnt", 160'(winCnt), 160'(16'(cnt0 + 2)));

        // Accept offered on the same edge as the last row, occupancy 2
        load2(randWin(), randWin());
        runTo("sim_reach", 19);
        vldIpgu = 1'b1;
        ipguOutBufferQ = randWin();
        chk("sim_rdy0", 160'(rdyHeu), 160'(0));
        step();
        chk("sim_rdy1", 160'(rdyHeu), 160'(1));
        chk("sim_row0", 160'(rowIdx), 160'(0));
        step();
        vldIpgu = 1'b0;
        chk("sim_rdy2", 160'(rdyHeu), 160'(0));
        drain("sim_drain");

        // Reset mid-stream with occupancy 2
        load2(randWin(), randWin());
        runTo("rs_reach", 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_vld", 160'(rowVld), 160'(0));
        chk("rs_rdy", 160'(rdyHeu), 160'(0));
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_rel_rdy", 160'(rdyHeu), 160'(1));
        chk("rs_rel_cnt", 160'(winCnt), 160'(0));
        chk("rs_rel_vld", 160'(rowVld), 160'(0));
        ipguOutBufferQ = randWin();
        vldIpgu = 1'b1;
        rowRdy = 1'b1;
        step();
        vldIpgu = 1'b0;
        chk("rs_row0", 160'(rowIdx), 160'(0));
        drain("rs_drain");
        chk("rs_cnt1", 160'(winCnt), 160'(1));

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            vldIpgu = 1'($urandom_range(0, 1));
            rowRdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) ipguOutBufferQ = randWin();
            step();
        end
        vldIpgu = 1'b0;
        drain("rnd_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
